async_fifo_wr_ctrl: RTL and testbench

Write-domain controller for the asynchronous FIFO, generalising the existing fixed 4-bit write-pointer block to any depth of 2^ADDR_WIDTH.
- Keeps a binary write pointer with one extra wrap bit and publishes its registered Gray form to the read domain.
- Synchronises the read domain's Gray pointer internally through a parameterised flop chain.
- Produces full, almost-full, fill level, memory write enable and a sticky overflow flag.
- Sits between the write-side producer and the dual-port FIFO RAM; its Gray pointer feeds the read controller's synchroniser.

---
 rtl/async_fifo_wr_ctrl.sv | 85 ++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller for the asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and registered full / almost-full / fill / overflow flags.
module async_fifo_wr_ctrl #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  W_CLK,
   input  logic                  W_RST_N,
   input  logic                  W_INC_EN,
   input  logic [ADDR_WIDTH:0]   R_GRAY_PTR,
   input  logic [ADDR_WIDTH:0]   AF_THRESH,
   input  logic                  W_OVF_CLR,
   output logic [ADDR_WIDTH-1:0] W_ADDR,
   output logic                  W_MEM_EN,
   output logic [ADDR_WIDTH:0]   W_GRAY_PTR,
   output logic                  W_FULL,
   output logic                  W_ALMOST_FULL,
   output logic [ADDR_WIDTH:0]   W_FILL_LVL,
   output logic                  W_OVERFLOW
);

   localparam int PW = ADDR_WIDTH + 1;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0]                  wbin_q, wbin_d;
   logic [PW-1:0]                  wgray_q, wgray_d;
   logic [PW-1:0]                  fill_q, fill_d;
   logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
   logic                           full_q, full_d;
   logic                           af_q, af_d;
   logic                           ovf_q, ovf_d;
   logic                           wr_acc;
   logic [PW-1:0]                  rgray_s, rbin_s;

   always_comb begin
      wr_acc  = W_INC_EN & ~full_q;
      wbin_d  = wbin_q + {{(PW-1){1'b0}}, wr_acc};
      wgray_d = wbin_d ^ (wbin_d >> 1);
      rgray_s = sync_q[SYNC_STAGES-1];
      rbin_s  = gray2bin(rgray_s);
      // Full when the write pointer is exactly one lap ahead of the synced read pointer.
      full_d  = (wgray_d == {~rgray_s[PW-1:PW-2], rgray_s[PW-3:0]});
      fill_d  = wbin_d - rbin_s;
      af_d    = (fill_d >= AF_THRESH);
      ovf_d   = (W_INC_EN & full_q) | (ovf_q & ~W_OVF_CLR);
   end

   always_ff @(posedge W_CLK or negedge W_RST_N) begin
      if (!W_RST_N) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         fill_q  <= '0;
         sync_q  <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         fill_q  <= fill_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], R_GRAY_PTR};
         full_q  <= full_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
      end
   end

   // Strobe is held off while reset is asserted so no RAM write escapes a reset.
   assign W_MEM_EN      = wr_acc & W_RST_N;
   assign W_ADDR        = wbin_q[ADDR_WIDTH-1:0];
   assign W_GRAY_PTR    = wgray_q;
   assign W_FULL        = full_q;
   assign W_ALMOST_FULL = af_q;
   assign W_FILL_LVL    = fill_q;
   assign W_OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl (ADDR_WIDTH=3, SYNC_STAGES=2): directed scenarios plus
// randomized traffic against an occupancy-arithmetic reference model.
module tb_async_fifo_wr_ctrl;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int MOD   = 16;

   logic          W_CLK = 1'b0;
   logic          W_RST_N = 1'b1;
   logic          W_INC_EN = 1'b0;
   logic [AW:0]   R_GRAY_PTR = '0;
   logic [AW:0]   AF_THRESH = 4'd6;
   logic          W_OVF_CLR = 1'b0;
   logic [AW-1:0] W_ADDR;
   logic          W_MEM_EN;
   logic [AW:0]   W_GRAY_PTR;
   logic          W_FULL;
   logic          W_ALMOST_FULL;
   logic [AW:0]   W_FILL_LVL;
   logic          W_OVERFLOW;

   async_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
      .W_CLK(W_CLK), .W_RST_N(W_RST_N), .W_INC_EN(W_INC_EN), .R_GRAY_PTR(R_GRAY_PTR),
      .AF_THRESH(AF_THRESH), .W_OVF_CLR(W_OVF_CLR), .W_ADDR(W_ADDR), .W_MEM_EN(W_MEM_EN),
      .W_GRAY_PTR(W_GRAY_PTR), .W_FULL(W_FULL), .W_ALMOST_FULL(W_ALMOST_FULL),
      .W_FILL_LVL(W_FILL_LVL), .W_OVERFLOW(W_OVERFLOW)
   );

   always #5 W_CLK = ~W_CLK;

   int checks = 0;
   int failures = 0;

   // Reference model: write count, read pointer as seen two write edges later, flags.
   int       m_w, m_sp0, m_sp1, m_fill, cur_r;
   bit       m_full, m_af, m_ovf;
   bit       exp_mem_en, obs_mem_en;
   int       exp_addr;
   logic [AW-1:0] obs_addr;
   logic [AW:0]   prev_gray;

   function automatic logic [AW:0] to_gray(input int b);
      logic [AW:0] v;
      v = (AW+1)'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_w = 0; m_sp0 = 0; m_sp1 = 0; m_fill = 0; cur_r = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
   endtask

   task automatic cycle(input bit inc, input int rbin, input bit clr);
      int  rs;
      bit  was_full;
      W_INC_EN = inc; R_GRAY_PTR = to_gray(rbin); W_OVF_CLR = clr; cur_r = rbin % MOD;
      #1;
      exp_mem_en = inc && !m_full;
      exp_addr   = m_w % DEPTH;
      obs_mem_en = W_MEM_EN;
      obs_addr   = W_ADDR;
      prev_gray  = W_GRAY_PTR;
      @(posedge W_CLK);
      was_full = m_full;
      rs       = m_sp1;
      m_w      = (m_w + (exp_mem_en ? 1 : 0)) % MOD;
      m_fill   = (m_w - rs + MOD) % MOD;
      m_full   = (m_fill == DEPTH);
      m_af     = (m_fill >= int'(AF_THRESH));
      m_ovf    = (inc && was_full) || (m_ovf && !clr);
      m_sp1    = m_sp0;
      m_sp0    = cur_r;
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] outs;
      W_INC_EN = 0; W_OVF_CLR = 0; R_GRAY_PTR = '0; AF_THRESH = 4'd6;
      #2 W_RST_N = 1'b0;
      repeat (2) @(posedge W_CLK);
      #1;
      outs = {W_ADDR, W_MEM_EN, W_GRAY_PTR, W_FULL, W_ALMOST_FULL, W_FILL_LVL, W_OVERFLOW};
      checks++;
      if (outs !== 16'h0) begin
         failures++; $display("FAIL reset_init outputs got=%h exp=0", outs);
      end
      W_RST_N = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) cycle(1, 0, 0);
      checks++;
      if (W_GRAY_PTR !== to_gray(3)) begin
         failures++; $display("FAIL reset_pre_burst gray got=%b exp=%b", W_GRAY_PTR, to_gray(3));
      end
      W_INC_EN = 1'b1;
      #2 W_RST_N = 1'b0;
      #1;
      outs = {W_ADDR, W_MEM_EN, W_GRAY_PTR, W_FULL, W_ALMOST_FULL, W_FILL_LVL, W_OVERFLOW};
      checks++;
      if (outs !== 16'h0) begin
         failures++; $display("FAIL reset_midburst outputs got=%h exp=0", outs);
      end
      @(posedge W_CLK);
      #1;
      W_INC_EN = 1'b0;
      W_RST_N = 1'b1;
      model_reset();
      #1;
      checks++;
      if (W_GRAY_PTR !== 4'b0000 || W_ADDR !== 3'd0 || W_FILL_LVL !== 4'd0) begin
         failures++;
         $display("FAIL reset_release gray=%b addr=%0d fill=%0d exp=0/0/0", W_GRAY_PTR, W_ADDR, W_FILL_LVL);
      end
   endtask

   task automatic test_fill_to_full();
      for (int i = 1; i <= 10; i++) begin
         cycle(1, 0, 0);
         checks++;
         if (obs_mem_en !== (i <= 8)) begin
            failures++; $display("FAIL fill_mem_en cyc=%0d got=%b exp=%b", i, obs_mem_en, (i <= 8));
         end
         if (i <= 8) begin
            checks++;
            if (obs_addr !== 3'(i - 1)) begin
               failures++; $display("FAIL fill_addr cyc=%0d got=%0d exp=%0d", i, obs_addr, i - 1);
            end
         end
         checks++;
         if (W_ALMOST_FULL !== (i >= 6)) begin
            failures++; $display("FAIL fill_af cyc=%0d got=%b exp=%b", i, W_ALMOST_FULL, (i >= 6));
         end
         checks++;
         if (W_FULL !== (i >= 8)) begin
            failures++; $display("FAIL fill_full cyc=%0d got=%b exp=%b", i, W_FULL, (i >= 8));
         end
         checks++;
         if (W_FILL_LVL !== 4'((i >= 8) ? 8 : i)) begin
            failures++; $display("FAIL fill_lvl cyc=%0d got=%0d exp=%0d", i, W_FILL_LVL, (i >= 8) ? 8 : i);
         end
         checks++;
         if (W_OVERFLOW !== (i >= 9)) begin
            failures++; $display("FAIL fill_ovf cyc=%0d got=%b exp=%b", i, W_OVERFLOW, (i >= 9));
         end
         if (i == 8) begin
            checks++;
            if (W_GRAY_PTR !== 4'b1100) begin
               failures++; $display("FAIL fill_gray got=%b exp=1100", W_GRAY_PTR);
            end
         end
      end
   endtask

   task automatic test_ovf_clear();
      cycle(1, 0, 1);
      checks++;
      if (W_OVERFLOW !== 1'b1 || obs_mem_en !== 1'b0) begin
         failures++; $display("FAIL ovf_race ovf=%b mem_en=%b exp=1/0", W_OVERFLOW, obs_mem_en);
      end
      cycle(0, 0, 1);
      checks++;
      if (W_OVERFLOW !== 1'b0) begin
         failures++; $display("FAIL ovf_clear got=%b exp=0", W_OVERFLOW);
      end
      cycle(0, 0, 0);
      checks++;
      if (W_OVERFLOW !== 1'b0 || W_FULL !== 1'b1) begin
         failures++; $display("FAIL ovf_hold ovf=%b full=%b exp=0/1", W_OVERFLOW, W_FULL);
      end
   endtask

   task automatic test_drain();
      for (int e = 1; e <= 3; e++) begin
         cycle(0, 3, 0);
         checks++;
         if (e < 3 && (W_FULL !== 1'b1 || W_FILL_LVL !== 4'd8)) begin
            failures++; $display("FAIL drain_early edge=%0d full=%b fill=%0d exp=1/8", e, W_FULL, W_FILL_LVL);
         end else if (e == 3 && (W_FULL !== 1'b0 || W_FILL_LVL !== 4'd5 || W_ALMOST_FULL !== 1'b0)) begin
            failures++;
            $display("FAIL drain_seen full=%b fill=%0d af=%b exp=0/5/0", W_FULL, W_FILL_LVL, W_ALMOST_FULL);
         end
      end
   endtask

   task automatic test_simultaneous();
      cycle(1, 3, 0);
      cycle(1, 3, 0);
      checks++;
      if (W_FILL_LVL !== 4'd7) begin
         failures++; $display("FAIL simul_setup fill got=%0d exp=7", W_FILL_LVL);
      end
      cycle(0, 4, 0);
      cycle(0, 4, 0);
      checks++;
      if (W_FILL_LVL !== 4'd7) begin
         failures++; $display("FAIL simul_wait fill got=%0d exp=7", W_FILL_LVL);
      end
      cycle(1, 4, 0);
      checks++;
      if (obs_mem_en !== 1'b1 || W_FILL_LVL !== 4'd7 || W_FULL !== 1'b0 || W_ALMOST_FULL !== 1'b1) begin
         failures++;
         $display("FAIL simul_edge mem_en=%b fill=%0d full=%b af=%b exp=1/7/0/1",
                  obs_mem_en, W_FILL_LVL, W_FULL, W_ALMOST_FULL);
      end
   endtask

   task automatic test_wrap_random();
      int  wraps, prev_w, r;
      bit  inc, clr;
      int  thr[4];
      wraps = 0;
      thr[0] = 6; thr[1] = 0; thr[2] = 9; thr[3] = $urandom_range(1, 8);
      for (int seg = 0; seg < 4; seg++) begin
         AF_THRESH = 4'(thr[seg]);
         for (int c = 0; c < 150; c++) begin
            inc = ($urandom % 100) < 60;
            clr = ($urandom % 100) < 10;
            r   = cur_r;
            if (((m_w - r + MOD) % MOD) > 0 && ($urandom % 100) < 50) r = (r + 1) % MOD;
            prev_w = m_w;
            cycle(inc, r, clr);
            if (m_w < prev_w) wraps++;
            checks++;
            if (obs_mem_en !== exp_mem_en) begin
               failures++; $display("FAIL rnd_mem_en s=%0d c=%0d got=%b exp=%b", seg, c, obs_mem_en, exp_mem_en);
            end
            checks++;
            if (obs_addr !== 3'(exp_addr)) begin
               failures++; $display("FAIL rnd_addr s=%0d c=%0d got=%0d exp=%0d", seg, c, obs_addr, exp_addr);
            end
            checks++;
            if (W_GRAY_PTR !== to_gray(m_w)) begin
               failures++; $display("FAIL rnd_gray s=%0d c=%0d got=%b exp=%b", seg, c, W_GRAY_PTR, to_gray(m_w));
            end
            checks++;
            if ($countones(W_GRAY_PTR ^ prev_gray) > 1) begin
               failures++; $display("FAIL rnd_gray_step s=%0d c=%0d from=%b to=%b", seg, c, prev_gray, W_GRAY_PTR);
            end
            checks++;
            if (W_FULL !== m_full) begin
               failures++; $display("FAIL rnd_full s=%0d c=%0d got=%b exp=%b", seg, c, W_FULL, m_full);
            end
            checks++;
            if (W_FILL_LVL !== 4'(m_fill)) begin
               failures++; $display("FAIL rnd_fill s=%0d c=%0d got=%0d exp=%0d", seg, c, W_FILL_LVL, m_fill);
            end
            checks++;
            if (W_ALMOST_FULL !== m_af) begin
               failures++; $display("FAIL rnd_af s=%0d c=%0d got=%b exp=%b", seg, c, W_ALMOST_FULL, m_af);
            end
            checks++;
            if (W_OVERFLOW !== m_ovf) begin
               failures++; $display("FAIL rnd_ovf s=%0d c=%0d got=%b exp=%b", seg, c, W_OVERFLOW, m_ovf);
            end
         end
      end
      AF_THRESH = 4'd6;
      checks++;
      if (wraps < 2) begin
         failures++; $display("FAIL rnd_wrap_count got=%0d exp>=2", wraps);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_fill_to_full();
      test_ovf_clear();
      test_drain();
      test_simultaneous();
      test_wrap_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
